// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the main system bus: grants one requester at a time,
// holds the grant while the owner is busy and revokes unused grants after a timeout.
module bus_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned GNT_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  busy,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] owner_id,
    output logic                owner_valid,
    output logic                timeout_err
);

    localparam int unsigned CNT_W = (GNT_TIMEOUT > 2) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        OWNED   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] cand;

    // Scan downward so the candidate closest to ptr+1 is the last one written.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            cand = ID_WIDTH'((32'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            owner_id    <= '0;
            owner_valid <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            ptr         <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant         <= '0;
                        grant[winner] <= 1'b1;
                        owner_id      <= winner;
                        owner_valid   <= 1'b1;
                        ptr           <= winner;
                        wait_cnt      <= '0;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (busy[owner_id]) begin
                        state <= OWNED;
                    end else if (!req[owner_id]) begin
                        grant       <= '0;
                        owner_valid <= 1'b0;
                        state       <= RELEASE;
                    end else if (wait_cnt == CNT_LAST) begin
                        grant       <= '0;
                        owner_valid <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end
                end
                OWNED: begin
                    // Only the owner's busy matters; req is irrelevant once the bus is in use.
                    if (!busy[owner_id]) begin
                        grant       <= '0;
                        owner_valid <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    grant       <= '0;
                    owner_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
